iir_out_requant: RTL and testbench

IIR_OUT_REQUANT -- requirements
Module: iir_out_requant

---
 rtl/iir_out_requant.sv | 109 ++++++++++
 tb/tb_iir_out_requant.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_out_requant.sv
// Requantizes a full-precision IIR output to WIDTH bits (round-half-up, saturate)
// and buffers the result in a show-ahead FIFO with sticky saturation/drop flags.
module iir_out_requant #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 14,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [2*WIDTH-1:0]         data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       sat_flag,
  output logic                       overflow,
  input  logic                       clr_flags
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic signed [DW:0] RND   = (DW+1)'(1) << (SHIFT - 1);
  localparam logic signed [DW:0] MAX_V = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [DW:0] MIN_V = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   POS_SAT = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   NEG_SAT = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [DW:0] ext_c;
  logic signed [DW:0] sum_c;
  logic signed [DW:0] shr_c;
  logic [WIDTH-1:0]   rq_c;
  logic               sat_c;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_data;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               full_c;
  logic               pop_c;
  logic               push_c;
  logic               drop_c;

  // Round by adding half an LSB in one extra bit so the sum cannot wrap, then clamp.
  always_comb begin
    ext_c = {data_in[DW-1], data_in};
    sum_c = ext_c + RND;
    shr_c = sum_c >>> SHIFT;
    rq_c  = shr_c[WIDTH-1:0];
    sat_c = 1'b0;
    if (shr_c > MAX_V) begin
      rq_c  = POS_SAT;
      sat_c = 1'b1;
    end else if (shr_c < MIN_V) begin
      rq_c  = NEG_SAT;
      sat_c = 1'b1;
    end
  end

  always_comb begin
    full_c = (fill_level == CW'(DEPTH));
    pop_c  = out_valid & out_ready;
    push_c = s1_valid & (~full_c | pop_c);
    drop_c = s1_valid & full_c & ~pop_c;
  end

  assign out_valid = (fill_level != '0);
  assign data_out  = out_valid ? mem[rd_ptr] : '0;

  // Stage 1 register and sticky flags; a new event wins over a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= rq_c;
      sat_flag <= (sat_flag & ~clr_flags) | (in_valid & sat_c);
      overflow <= (overflow & ~clr_flags) | drop_c;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= s1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_c, pop_c})
        2'b10:   fill_level <= fill_level + CW'(1);
        2'b01:   fill_level <= fill_level - CW'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_out_requant.sv
// Self-checking bench for iir_out_requant: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_iir_out_requant;

  localparam int unsigned W = 16;
  localparam int unsigned S = 14;
  localparam int unsigned D = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [2*W-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_out;
  logic [3:0]    fill_level;
  logic          sat_flag;
  logic          overflow;
  logic          clr_flags;

  iir_out_requant #(.WIDTH(W), .SHIFT(S), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .fill_level(fill_level), .sat_flag(sat_flag), .overflow(overflow),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] q[$];
  logic         m_s1v;
  logic [W-1:0] m_s1d;
  logic         m_sat;
  logic         m_ovf;

  typedef struct {
    logic [31:0] din;
    logic [15:0] exp_out;
    logic        exp_sat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Requantize: floor((x + 2^(S-1)) / 2^S), clamped to the signed W-bit range.
  function automatic logic [W-1:0] rq(input logic [31:0] d);
    longint v;
    v = longint'(signed'(d)) + (longint'(1) << (S - 1));
    v = v >>> S;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return W'(v);
  endfunction

  function automatic bit rq_sat(input logic [31:0] d);
    longint v;
    v = (longint'(signed'(d)) + (longint'(1) << (S - 1))) >>> S;
    return (v > 32767) || (v < -32768);
  endfunction

  task automatic model_reset();
    q.delete();
    m_s1v = 1'b0;
    m_s1d = '0;
    m_sat = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    bit pop, full, drop;
    pop  = (q.size() != 0) && out_ready;
    full = (q.size() == D);
    drop = 1'b0;
    if (pop) void'(q.pop_front());
    if (m_s1v) begin
      if (!full || pop) q.push_back(m_s1d);
      else drop = 1'b1;
    end
    m_sat = (m_sat & ~clr_flags) | (in_valid & rq_sat(data_in));
    m_ovf = (m_ovf & ~clr_flags) | drop;
    m_s1v = in_valid;
    if (in_valid) m_s1d = rq(data_in);
  endtask

  task automatic check_outputs();
    logic [W-1:0] exp_d;
    exp_d = (q.size() != 0) ? q[0] : '0;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("data_out", 32'(data_out), 32'(exp_d));
    chk("fill_level", 32'(fill_level), 32'(q.size()));
    chk("sat_flag", 32'(sat_flag), 32'(m_sat));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy, input logic clr);
    in_valid  = v;
    data_in   = d;
    out_ready = rdy;
    clr_flags = clr;
  endtask

  vec_t tbl[6];
  logic [W-1:0] got[$];
  logic [31:0]  hist[$];

  initial begin
    tbl[0] = '{32'h1000_0000, 16'h4000, 1'b0};
    tbl[1] = '{32'h0000_2000, 16'h0001, 1'b0};
    tbl[2] = '{32'h0000_1FFF, 16'h0000, 1'b0};
    tbl[3] = '{32'hFFFF_E000, 16'h0000, 1'b0};
    tbl[4] = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
    tbl[5] = '{32'h8000_0000, 16'h8000, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_outputs();
    chk("reset_data_out", 32'(data_out), 32'h0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Rounding and saturation vectors
    foreach (tbl[i]) begin
      drive(1'b0, '0, 1'b1, 1'b1);
      tick();
      drive(1'b1, tbl[i].din, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      chk($sformatf("vec%0d_data", i), 32'(data_out), 32'(tbl[i].exp_out));
      chk($sformatf("vec%0d_sat", i), 32'(sat_flag), 32'(tbl[i].exp_sat));
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    chk("sat_cleared", 32'(sat_flag), 32'h0);

    // Backpressure: 10 pushes into an 8-deep FIFO
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'(i) << S, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    chk("bp_fill", 32'(fill_level), 32'd8);
    chk("bp_overflow", 32'(overflow), 32'h1);
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) got.push_back(data_out);
      tick();
    end
    chk("bp_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("bp_order%0d", i), 32'(got[i]), 32'(i + 1));
    chk("bp_drained", 32'(fill_level), 32'd0);

    // Streaming at full rate
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    hist.delete();
    for (int t = 0; t < 100; t++) begin
      drive(1'b1, $urandom, 1'b1, 1'b0);
      hist.push_back(data_in);
      tick();
      if (t >= 1) chk("stream_delay", 32'(data_out), 32'(rq(hist[t-1])));
      chk("stream_fill_le1", 32'(fill_level <= 4'd1), 32'h1);
    end
    chk("stream_overflow", 32'(overflow), 32'h0);

    // Full FIFO with simultaneous push and pop
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'(i + 20) << S, 1'b0, 1'b0);
      tick();
    end
    chk("full_reached", 32'(fill_level), 32'd8);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(i + 40) << S, 1'b1, 1'b0);
      tick();
      chk("full_pushpop_fill", 32'(fill_level), 32'd8);
    end
    chk("full_pushpop_ovf", 32'(overflow), 32'h0);

    // Asynchronous reset mid-run
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(i + 60) << S, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    chk("pre_reset_fill", 32'(fill_level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_fill", 32'(fill_level), 32'h0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'd77 << S, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("post_rst_first", 32'(data_out), 32'd77);
    tick();

    // Randomized traffic against the model
    for (int t = 0; t < 400; t++) begin
      logic [31:0] d;
      case ($urandom_range(0, 5))
        0:       d = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
        1:       d = 32'h8000_0000 + 32'($urandom_range(0, 3));
        2:       d = 32'($signed($urandom_range(0, 65535)) - 32768);
        default: d = $urandom;
      endcase
      drive(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
